// File: rtl/hps_pixel_fifo_xfer.sv
`default_nettype none
// ============================================================================
// Module   : hps_pixel_fifo_xfer
// Purpose  : Pixel FIFO between a streaming pixel producer and a CPU reading
//            through an Avalon-MM slave. A small frame FSM (IDLE/STREAM/DRAIN/
//            DONE) accepts one frame, lets the CPU drain it, then raises a
//            done flag / level interrupt.
// Ports    : clk, rst_n             - clock, async active-low reset
//            pix_valid/data/last    - producer side, pix_ready back-pressure
//            address/read/write/    - Avalon-MM slave; reads take 2 cycles,
//            writedata/readdata/      writes 1 cycle
//            waitrequest
//            frame_irq              - level irq (DONE_FLAG & IRQ_EN)
//            out_state              - FSM state code for debug
// Revision : 1.0 - initial release
// ============================================================================
module hps_pixel_fifo_xfer #(
  parameter int PIX_W = 24,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_last,
  output logic             pix_ready,
  input  logic [2:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             waitrequest,
  output logic             frame_irq,
  output logic [3:0]       out_state
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full_lvl = (c_aw+1)'(DEPTH);
  localparam logic [c_aw:0] c_one_lvl  = (c_aw+1)'(1);

  localparam logic [3:0] c_st_idle   = 4'd0;
  localparam logic [3:0] c_st_stream = 4'd1;
  localparam logic [3:0] c_st_drain  = 4'd2;
  localparam logic [3:0] c_st_done   = 4'd3;

  logic [3:0]       r_state;
  logic [3:0]       w_next_state;
  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_level;
  logic [31:0]      r_pix_count;
  logic             r_enable;
  logic             r_irq_en;
  logic             r_done_flag;
  logic             r_underflow;
  logic             r_rd_busy;
  logic             r_rd_data;
  logic [31:0]      r_readdata;

  logic             w_rd_start;
  logic             w_wr_acc;
  logic             w_ctrl_wr;
  logic             w_flush;
  logic             w_clr;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_rd_fin_data;
  logic             w_underflow_set;
  logic             w_done_set;
  logic             w_cnt_clr;
  logic [PIX_W-1:0] w_head_ahead;
  logic             w_head_ok;
  logic [31:0]      w_head32;
  logic [8:0]       w_level9;
  logic [31:0]      w_rd_mux;
  logic             w_unused;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  assign w_rd_start = read && !r_rd_busy;
  assign w_wr_acc   = write && !read;          // a write alongside a read is dropped
  assign w_ctrl_wr  = w_wr_acc && (address == 3'd1);
  assign w_flush    = w_ctrl_wr && writedata[2];
  assign w_clr      = w_ctrl_wr && writedata[3];
  assign w_unused   = ^writedata[31:4];

  // --------------------------------------------------------------------------
  // FIFO flags and transfer strobes
  // --------------------------------------------------------------------------
  assign w_empty         = (r_level == '0);
  assign w_full          = (r_level == c_full_lvl);
  assign w_push          = pix_valid && pix_ready && !w_flush;
  assign w_rd_fin_data   = r_rd_busy && r_rd_data;
  assign w_pop           = w_rd_fin_data && !w_empty && !w_flush;
  assign w_underflow_set = w_rd_fin_data && w_empty;
  assign w_done_set      = (w_next_state == c_st_done) && (r_state != c_st_done);
  assign w_cnt_clr       = w_flush ||
                           ((w_next_state == c_st_stream) &&
                            ((r_state == c_st_idle) || (r_state == c_st_done)));

  // readdata is registered at the end of the first read cycle but must show
  // the head as seen in the second cycle, when the pop happens. Only a push
  // into an empty FIFO can change the head across that boundary, so look
  // ahead at the incoming pixel in that case.
  assign w_head_ok    = !w_empty || w_push;
  assign w_head_ahead = w_empty ? pix_data : r_mem[r_rd_ptr];
  assign w_level9     = 9'(r_level);

  generate
    if (PIX_W < 32) begin : g_pad
      assign w_head32 = {{(32-PIX_W){1'b0}}, w_head_ahead};
    end else begin : g_nopad
      assign w_head32 = w_head_ahead;
    end
  endgenerate

  always_comb begin
    w_rd_mux = '0;
    case (address)
      3'd0:    w_rd_mux = {15'd0, w_level9, 5'd0, r_underflow, r_done_flag, ~w_empty};
      3'd1:    w_rd_mux = {30'd0, r_irq_en, r_enable};
      3'd2:    w_rd_mux = w_head_ok ? w_head32 : 32'd0;
      3'd3:    w_rd_mux = r_pix_count;
      default: w_rd_mux = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO storage (not reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pix_data;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers, level and pixel counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_pix_count <= '0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_level <= r_level + 1'b1;
        else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      end
      if (w_cnt_clr)  r_pix_count <= '0;
      else if (w_pop) r_pix_count <= r_pix_count + 32'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Control / status registers and read pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_done_flag <= 1'b0;
      r_underflow <= 1'b0;
      r_rd_busy   <= 1'b0;
      r_rd_data   <= 1'b0;
      r_readdata  <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_enable <= writedata[0];
        r_irq_en <= writedata[1];
      end
      // Setting wins over a simultaneous clear.
      if (w_done_set) r_done_flag <= 1'b1;
      else if (w_clr) r_done_flag <= 1'b0;
      if (w_underflow_set) r_underflow <= 1'b1;
      else if (w_clr)      r_underflow <= 1'b0;
      r_rd_busy <= w_rd_start;
      r_rd_data <= w_rd_start && (address == 3'd2);
      if (w_rd_start) r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  // Gated by rst_n so the stall drops the moment reset aborts an access.
  assign waitrequest = read && !r_rd_busy && rst_n;

  // --------------------------------------------------------------------------
  // Frame FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_next_state;
  end

  // --------------------------------------------------------------------------
  // Frame FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    if (w_flush) begin
      w_next_state = writedata[0] ? c_st_stream : c_st_idle;
    end else if (!r_enable) begin
      w_next_state = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle:   w_next_state = c_st_stream;
        c_st_stream: if (w_push && pix_last) w_next_state = c_st_drain;
        c_st_drain:  if (w_pop && (r_level == c_one_lvl)) w_next_state = c_st_done;
        c_st_done:   if (w_clr && writedata[0]) w_next_state = c_st_stream;
        default:     w_next_state = c_st_idle;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    pix_ready = r_enable && !w_full && (r_state == c_st_stream);
    frame_irq = r_done_flag && r_irq_en;
    out_state = r_state;
  end

endmodule
`default_nettype wire

// File: tb/tb_hps_pixel_fifo_xfer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hps_pixel_fifo_xfer
// Purpose  : Self-checking bench for hps_pixel_fifo_xfer. A queue-based frame
//            model predicts register reads, pixel back-pressure and state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hps_pixel_fifo_xfer;

  localparam int PIX_W = 24;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pix_valid = 1'b0;
  logic [PIX_W-1:0] pix_data = '0;
  logic             pix_last = 1'b0;
  logic             pix_ready;
  logic [2:0]       address = '0;
  logic             read = 1'b0;
  logic             write = 1'b0;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic             waitrequest;
  logic             frame_irq;
  logic [3:0]       out_state;

  hps_pixel_fifo_xfer #(.PIX_W(PIX_W), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last), .pix_ready(pix_ready),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .waitrequest(waitrequest),
    .frame_irq(frame_irq), .out_state(out_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  logic [PIX_W-1:0] m_fifo[$];
  int               m_state;      // 0 idle, 1 stream, 2 drain, 3 done
  bit               m_en, m_irq, m_done, m_under;
  logic [31:0]      m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return m_en && (m_fifo.size() < DEPTH) && (m_state == 1);
  endfunction

  function automatic logic [31:0] m_status();
    logic [8:0] lv;
    lv = 9'(m_fifo.size());
    return {15'd0, lv, 5'd0, m_under, m_done, (m_fifo.size() != 0)};
  endfunction

  task automatic m_reset();
    m_fifo.delete();
    m_state = 0; m_en = 0; m_irq = 0; m_done = 0; m_under = 0; m_count = 0;
  endtask

  task automatic m_push(input logic [PIX_W-1:0] d, input bit last);
    m_fifo.push_back(d);
    if (last) m_state = 2;
  endtask

  task automatic m_pop(output logic [31:0] d);
    if (m_fifo.size() == 0) begin
      d = 32'd0;
      m_under = 1;
    end else begin
      d = 32'(m_fifo.pop_front());
      m_count++;
      if (m_state == 2 && m_fifo.size() == 0) begin
        m_state = 3;
        m_done = 1;
      end
    end
  endtask

  // ---------------- bench helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pins(input string tag);
    check({tag, "_state"}, 32'(out_state), 32'(m_state));
    check({tag, "_irq"}, 32'(frame_irq), 32'(m_done && m_irq));
    check({tag, "_ready"}, 32'(pix_ready), 32'(m_ready()));
  endtask

  task automatic push_px(input logic [PIX_W-1:0] d, input bit last);
    bit rdy;
    pix_valid = 1'b1; pix_data = d; pix_last = last;
    #1;
    rdy = m_ready();
    check("push_ready", 32'(pix_ready), 32'(rdy));
    tick();
    pix_valid = 1'b0; pix_last = 1'b0;
    if (rdy) m_push(d, last);
  endtask

  // CPU write plus one settle cycle, with an optional concurrent pixel.
  task automatic cpu_write(input logic [2:0] a, input logic [31:0] wd,
                           input bit pv, input logic [PIX_W-1:0] pd);
    bit rdy;
    address = a; writedata = wd; write = 1'b1;
    pix_valid = pv; pix_data = pd; pix_last = 1'b0;
    #1;
    check("wr_wait", 32'(waitrequest), 32'd0);
    rdy = m_ready();
    check("wr_ready", 32'(pix_ready), 32'(rdy));
    tick();
    write = 1'b0; pix_valid = 1'b0;
    if (a == 3'd1) begin
      if (wd[2]) begin
        m_fifo.delete();
        m_count = 0;
        m_state = wd[0] ? 1 : 0;
      end else begin
        if (pv && rdy) m_push(pd, 0);
        if (!m_en) m_state = 0;
        else if (wd[3] && wd[0] && m_state == 3) begin
          m_state = 1;
          m_count = 0;
        end
      end
      if (wd[3]) begin m_done = 0; m_under = 0; end
      m_en = wd[0]; m_irq = wd[1];
    end else if (pv && rdy) begin
      m_push(pd, 0);
    end
    tick();
    if (!m_en) m_state = 0;
    else if (m_state == 0) begin m_state = 1; m_count = 0; end
    chk_pins("wr");
  endtask

  // Two-cycle CPU read with optional pixels offered in each of the two cycles.
  task automatic cpu_read(input logic [2:0] a,
                          input bit pv1, input logic [PIX_W-1:0] d1, input bit l1,
                          input bit pv2, input logic [PIX_W-1:0] d2, input bit l2,
                          output logic [31:0] obs);
    bit rdy;
    logic [31:0] exp;
    address = a; read = 1'b1;
    pix_valid = pv1; pix_data = d1; pix_last = l1;
    #1;
    check("rd_wait1", 32'(waitrequest), 32'd1);
    rdy = m_ready();
    check("rd_ready1", 32'(pix_ready), 32'(rdy));
    tick();
    if (pv1 && rdy) m_push(d1, l1);
    pix_valid = pv2; pix_data = d2; pix_last = l2;
    #1;
    check("rd_wait2", 32'(waitrequest), 32'd0);
    rdy = m_ready();
    check("rd_ready2", 32'(pix_ready), 32'(rdy));
    case (a)
      3'd0:    exp = m_status();
      3'd1:    exp = {30'd0, m_irq, m_en};
      3'd2:    m_pop(exp);
      3'd3:    exp = m_count;
      default: exp = 32'd0;
    endcase
    obs = readdata;
    check($sformatf("rd_data_a%0d", a), readdata, exp);
    tick();
    read = 1'b0; pix_valid = 1'b0; pix_last = 1'b0;
    if (pv2 && rdy) m_push(d2, l2);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] obs);
    cpu_read(a, 0, '0, 0, 0, '0, 0, obs);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    read = 0; write = 0; pix_valid = 0; pix_last = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0]      v;
    logic [PIX_W-1:0] d;
    int               n, sent, guard;
    bit               pv2, irq;

    do_reset();
    check("rst_readdata", readdata, 32'd0);
    check("rst_wait", 32'(waitrequest), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd0);
    check("rst_irq", 32'(frame_irq), 32'd0);
    check("rst_state", 32'(out_state), 32'd0);
    rd(3'd0, v);
    rd(3'd3, v);

    // One 4-pixel frame, drained by the CPU.
    cpu_write(3'd1, 32'h1, 0, '0);
    check("frame_stream", 32'(out_state), 32'd1);
    for (int i = 0; i < 4; i++) push_px(PIX_W'(32'h100 + i), i == 3);
    check("frame_drain", 32'(out_state), 32'd2);
    for (int i = 0; i < 4; i++) begin
      rd(3'd2, v);
      check("frame_data", v, 32'h100 + i);
    end
    check("frame_done", 32'(out_state), 32'd3);
    rd(3'd0, v);
    check("frame_doneflag", 32'(v[1]), 32'd1);
    rd(3'd3, v);
    check("frame_count", v, 32'd4);

    // Interrupt and CLR back to streaming.
    cpu_write(3'd1, 32'h3, 0, '0);
    check("irq_high", 32'(frame_irq), 32'd1);
    cpu_write(3'd1, 32'hB, 0, '0);
    check("irq_low", 32'(frame_irq), 32'd0);
    check("clr_stream", 32'(out_state), 32'd1);
    rd(3'd3, v);
    check("clr_count", v, 32'd0);

    // Underflow on empty DATA read, then cleared by CLR.
    rd(3'd2, v);
    check("uf_data", v, 32'd0);
    rd(3'd0, v);
    check("uf_flag", 32'(v[2]), 32'd1);
    rd(3'd3, v);
    cpu_write(3'd1, 32'hB, 0, '0);
    rd(3'd0, v);
    check("uf_cleared", 32'(v[2]), 32'd0);

    // Fill to full; 17th pixel blocked, also across a completing pop.
    for (int i = 0; i < DEPTH; i++) push_px(PIX_W'(32'h2000 + i), 0);
    push_px(PIX_W'(32'h2010), 0);
    check("full_ready", 32'(pix_ready), 32'd0);
    rd(3'd0, v);
    check("full_level", 32'(v[16:8]), 32'd16);
    cpu_read(3'd2, 1, PIX_W'(32'h2010), 0, 1, PIX_W'(32'h2010), 0, v);
    push_px(PIX_W'(32'h2010), 0);
    rd(3'd0, v);
    check("refill_level", 32'(v[16:8]), 32'd16);
    for (int i = 0; i < DEPTH; i++) rd(3'd2, v);

    // Push and pop in one cycle keep the level.
    for (int i = 0; i < 5; i++) push_px(PIX_W'($urandom()), 0);
    cpu_read(3'd2, 0, '0, 0, 1, PIX_W'(32'h3333), 0, v);
    rd(3'd0, v);
    check("pushpop_level", 32'(v[16:8]), 32'd5);

    // FLUSH with a concurrent pixel: dropped, FIFO empty.
    cpu_write(3'd1, 32'h5, 1, PIX_W'(32'h4444));
    rd(3'd0, v);
    check("flush_level", 32'(v[16:8]), 32'd0);

    // Read and write together: write ignored.
    address = 3'd1; read = 1'b1; write = 1'b1; writedata = 32'h0;
    #1;
    check("rw_wait1", 32'(waitrequest), 32'd1);
    tick();
    check("rw_data", readdata, {30'd0, m_irq, m_en});
    tick();
    read = 1'b0; write = 1'b0;
    tick();
    chk_pins("rw");

    // Pixel pushed into an empty FIFO during the first read cycle is returned.
    cpu_read(3'd2, 1, PIX_W'(32'h5A5A5A), 0, 0, '0, 0, v);

    // ENABLE=0 retains FIFO contents.
    push_px(PIX_W'(32'h600), 0);
    push_px(PIX_W'(32'h601), 0);
    cpu_write(3'd1, 32'h0, 0, '0);
    rd(3'd0, v);
    cpu_write(3'd1, 32'h1, 0, '0);
    rd(3'd2, v);
    rd(3'd2, v);

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 12);
      sent = 0;
      guard = 0;
      while ((sent < n || m_fifo.size() != 0) && guard < 200) begin
        guard++;
        if (sent < n && $urandom_range(0, 2) != 0) begin
          push_px(PIX_W'($urandom()), sent == n - 1);
          sent++;
        end else begin
          pv2 = (sent < n - 1) && ($urandom_range(0, 1) == 1);
          d = PIX_W'($urandom());
          cpu_read(3'd2, 0, '0, 0, pv2, d, 0, v);
          if (pv2) sent++;
        end
      end
      chk_pins("rnd_end");
      rd(3'd3, v);
      rd(3'd0, v);
      irq = ($urandom_range(0, 1) == 1);
      cpu_write(3'd1, 32'h1 | (32'(irq) << 1), 0, '0);
      cpu_write(3'd1, 32'h9 | (32'(irq) << 1), 0, '0);
    end

    // Reset during the first cycle of a DATA read.
    for (int i = 0; i < 3; i++) push_px(PIX_W'(32'h700 + i), 0);
    address = 3'd2; read = 1'b1;
    #1;
    check("arst_wait_pre", 32'(waitrequest), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_wait", 32'(waitrequest), 32'd0);
    check("arst_state", 32'(out_state), 32'd0);
    check("arst_ready", 32'(pix_ready), 32'd0);
    check("arst_readdata", readdata, 32'd0);
    read = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_reset();
    chk_pins("arst");
    rd(3'd0, v);
    check("arst_level", 32'(v[16:8]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/hps_pixel_fifo_xfer.md
HPS_PIXEL_FIFO_XFER -- requirements
Module: hps_pixel_fifo_xfer

Interface
REQ-001 The block SHALL have parameter PIX_W, default 24: pixel width in bits, legal range 1..32.
REQ-002 The block SHALL have parameter DEPTH, default 16: FIFO depth in pixels, a power of 2 from 2 to 256.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset; its ports SHALL include:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have the following pixel-side ports:
- pix_valid  in  1  producer presents a pixel.
- pix_data  in  PIX_W  pixel value.
- pix_last  in  1  qualifies the last pixel of a frame.
- pix_ready  out  1  block accepts the pixel this cycle.
REQ-005 The block SHALL have the following CPU-side Avalon-MM slave ports:
- address  in  3  register select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- waitrequest  out  1  stall of the CPU access.
REQ-006 The block SHALL have the following status ports:
- frame_irq  out  1  level, high while DONE_FLAG=1 and IRQ_EN=1.
- out_state  out  4  current FSM state code, for debug.

Function
REQ-007 Register map:
- addr0 STATUS (RO): bit0 NOT_EMPTY, bit1 DONE_FLAG, bit2 UNDERFLOW (sticky), bits[16:8] LEVEL.
- addr1 CONTROL (RW): bit0 ENABLE, bit1 IRQ_EN, bit2 FLUSH (self-clearing, reads 0), bit3 CLR (write-1 clears DONE_FLAG and UNDERFLOW).
- addr2 DATA (RO, pops one pixel): returns the pixel zero-extended to 32 bits.
- addr3 PIX_COUNT (RO): number of pixels popped since the last frame start.
- Other addresses read 0; writes to them are ignored.
REQ-008 Access timing:
- Every read SHALL take exactly 2 cycles: waitrequest=1 in the first cycle, 0 in the second, with readdata valid in the second.
- Writes SHALL complete in 1 cycle with waitrequest=0.
- Simultaneous read and write: the write is ignored.
REQ-009 The FIFO pop for an addr2 read SHALL occur in the second (completing) cycle only; the pixel returned is the head of the FIFO at that cycle.
REQ-010 An addr2 read while the FIFO is empty SHALL return 0, set UNDERFLOW, and leave the FIFO pointers and PIX_COUNT unchanged.
REQ-011 pix_ready SHALL be ENABLE && !full && state==STREAM; a push occurs when pix_valid && pix_ready.
REQ-012 Push when full is blocked even if a pop completes in the same cycle. Push and pop in the same cycle on a non-empty, non-full FIFO SHALL leave LEVEL unchanged.
REQ-013 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH. LEVEL SHALL range 0..DEPTH.
REQ-014 PIX_COUNT SHALL be a 32-bit counter that increments on each successful pop and wraps at 2^32.
REQ-015 FSM states and out_state codes:
- IDLE=0 to STREAM=1 when ENABLE=1; PIX_COUNT is cleared on this transition.
- STREAM to DRAIN=2 when a pixel with pix_last=1 is pushed.
- DRAIN to DONE=3 when LEVEL becomes 0 through a pop.
- DONE: DONE_FLAG is set on entry. DONE to STREAM on a CLR write with ENABLE=1; PIX_COUNT is cleared on this transition.
- Any state to IDLE when ENABLE=0; the FIFO contents are retained.
REQ-016 A FLUSH write SHALL, in the next cycle, empty the FIFO and clear PIX_COUNT, then go to STREAM if ENABLE=1, else IDLE.
REQ-017 FLUSH SHALL take priority over a push or pop in the same cycle. It does not clear DONE_FLAG.
REQ-018 If DONE_FLAG is set while a CLR write occurs in the same cycle, the set wins.

Reset
REQ-019 On rst_n=0, asynchronously:
- state=IDLE, pointers=0, LEVEL=0, PIX_COUNT=0;
- CONTROL=0, DONE_FLAG=0, UNDERFLOW=0;
- readdata=0, waitrequest=0, pix_ready=0, frame_irq=0, out_state=0.
The FIFO RAM contents need not be reset.
REQ-020 Reset asserted mid-frame or mid-read SHALL abort the access; the first cycle after deassertion obeys REQ-019.

Verification
REQ-021 Write CONTROL=0x1, push 4 pixels with pix_last on the 4th, do 4 addr2 reads -> data in order, out_state 1->2->3, DONE_FLAG=1, PIX_COUNT=4.
REQ-022 With DEPTH=16, push 17 pixels with no reads -> pix_ready=0 after the 16th, LEVEL=16; then one addr2 read and one push in the same cycle -> LEVEL=16, no data loss.
REQ-023 addr2 read with an empty FIFO -> readdata=0, UNDERFLOW=1, PIX_COUNT unchanged; CLR write -> UNDERFLOW=0.
REQ-024 With IRQ_EN=1, complete a frame -> frame_irq=1; CLR write -> frame_irq=0, state=STREAM, PIX_COUNT=0.
REQ-025 With LEVEL=5, FLUSH write concurrent with pix_valid=1 -> LEVEL=0 the next cycle and the pixel is dropped.
REQ-026 rst_n pulled low in the first cycle of an addr2 read -> waitrequest=0, LEVEL=0, out_state=0 immediately.
